// File: rtl/prbs7_checker.sv
// Receive-side PRBS7 (x^7+x^6+1, LSB-first) checker: self-seeds from the aligned word stream,
// locks after a run of clean words and counts bit errors, errored words and lock losses.
module prbs7_checker #(
   parameter int unsigned WORDWIDTH    = 32,
   parameter int unsigned LOCK_WORDS   = 4,
   parameter int unsigned UNLOCK_WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 aligned,
   input  logic [WORDWIDTH-1:0] din,
   input  logic                 clear,
   output logic                 locked,
   output logic                 err_flag,
   output logic [31:0]          bit_err_count,
   output logic [15:0]          word_err_count,
   output logic [7:0]           lock_loss_count
);

   localparam int unsigned NW   = $clog2(WORDWIDTH + 1);
   localparam int unsigned CNTW = 16;
   localparam logic [CNTW-1:0] LOCK_LAST   = CNTW'(LOCK_WORDS - 1);
   localparam logic [CNTW-1:0] UNLOCK_LAST = CNTW'(UNLOCK_WORDS - 1);

   typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

   state_e              state_q;
   logic [6:0]          pstate_q;
   logic [CNTW-1:0]     good_cnt_q;
   logic [CNTW-1:0]     bad_cnt_q;

   logic [WORDWIDTH-1:0] expected;
   logic [NW-1:0]        nerr;
   logic [6:0]           seed;
   logic                 seed_ok;
   logic [6:0]           pstate_next;
   logic [32:0]          bit_sum;

   // Unroll the recurrence W bits forward; ext[6:0] is the history, ext[7+i] is expected bit i.
   always_comb begin
      logic [WORDWIDTH+6:0] ext;
      ext      = '0;
      ext[6:0] = pstate_q;
      for (int i = 0; i < int'(WORDWIDTH); i++) begin
         ext[i+7] = ext[i] ^ ext[i+1];
      end
      expected = ext[WORDWIDTH+6:7];
   end

   always_comb begin
      logic [WORDWIDTH-1:0] diff;
      diff = din ^ expected;
      nerr = '0;
      for (int i = 0; i < int'(WORDWIDTH); i++) begin
         nerr = nerr + NW'(diff[i]);
      end
   end

   assign seed        = din[WORDWIDTH-1 -: 7];
   assign seed_ok     = |seed;
   assign pstate_next = expected[WORDWIDTH-1 -: 7];
   assign bit_sum     = {1'b0, bit_err_count} + 33'(nerr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StSearch;
         pstate_q        <= '0;
         good_cnt_q      <= '0;
         bad_cnt_q       <= '0;
         locked          <= 1'b0;
         err_flag        <= 1'b0;
         bit_err_count   <= '0;
         word_err_count  <= '0;
         lock_loss_count <= '0;
      end else begin
         err_flag <= 1'b0;
         if (!aligned) begin
            state_q <= StSearch;
            locked  <= 1'b0;
         end else begin
            unique case (state_q)
               StSearch: begin
                  if (seed_ok) begin
                     pstate_q   <= seed;
                     good_cnt_q <= '0;
                     state_q    <= StVerify;
                  end
               end
               StVerify: begin
                  if (nerr == '0) begin
                     pstate_q   <= pstate_next;
                     good_cnt_q <= good_cnt_q + CNTW'(1);
                     if (good_cnt_q == LOCK_LAST) begin
                        state_q   <= StLocked;
                        locked    <= 1'b1;
                        bad_cnt_q <= '0;
                     end
                  end else begin
                     good_cnt_q <= '0;
                     if (seed_ok) pstate_q <= seed;
                     else         state_q  <= StSearch;
                  end
               end
               StLocked: begin
                  pstate_q      <= pstate_next;
                  err_flag      <= (nerr != '0);
                  bit_err_count <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
                  if (nerr != '0) begin
                     if (word_err_count != 16'hFFFF) word_err_count <= word_err_count + 16'd1;
                     if (bad_cnt_q == UNLOCK_LAST) begin
                        if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
                        locked     <= 1'b0;
                        bad_cnt_q  <= '0;
                        good_cnt_q <= '0;
                        if (seed_ok) begin
                           pstate_q <= seed;
                           state_q  <= StVerify;
                        end else begin
                           state_q  <= StSearch;
                        end
                     end else begin
                        bad_cnt_q <= bad_cnt_q + CNTW'(1);
                     end
                  end else begin
                     bad_cnt_q <= '0;
                  end
               end
               default: state_q <= StSearch;
            endcase
         end
         // Clear overrides any increment made above in the same cycle.
         if (clear) begin
            bit_err_count   <= '0;
            word_err_count  <= '0;
            lock_loss_count <= '0;
         end
      end
   end

endmodule
